// File: rtl/encoder_pkg.sv
// Shared types and helpers for the request encoder queue.
package encoder_pkg;

    localparam int unsigned N = 4;
    localparam int unsigned W = $clog2(N);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_OFFER = 1'b1;

    function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
        return N'(1) << idx;
    endfunction

endpackage

// File: rtl/pri_encoder_comb.sv
// Combinational highest-set-bit encoder: index of the top set bit plus an any-set flag.
module pri_encoder_comb #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec_i[i]) idx_o = W'(i);
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/encoder_queue4to2.sv
// Sticky request queue: pends multi-hot request lines and serialises them as
// binary indices, highest first, over a valid/ready handshake.
module encoder_queue4to2
    import encoder_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         E,
    input  logic [N-1:0] A,
    input  logic         R,
    output logic [W-1:0] Y,
    output logic         V,
    output logic         O
);

    logic         state_q;
    logic [N-1:0] p_q;
    logic [W-1:0] y_q;
    logic         v_q;
    logic         o_q;

    logic         hs_c;
    logic [N-1:0] clr_c;
    logic [N-1:0] p_hold_c;
    logic [N-1:0] req_c;
    logic [N-1:0] rem_c;
    logic [N-1:0] p_d;
    logic         o_d;
    logic [W-1:0] p_idx_c;
    logic         p_any_c;
    logic [W-1:0] rem_idx_c;
    logic         rem_any_c;

    // Set wins over clear, so a line re-requested while being accepted stays pending.
    assign hs_c     = v_q & R;
    assign clr_c    = hs_c ? onehot(y_q) : '0;
    assign p_hold_c = p_q & ~clr_c;
    assign req_c    = E ? A : '0;
    assign p_d      = p_hold_c | req_c;
    assign o_d      = |(req_c & p_hold_c);
    assign rem_c    = p_q & ~onehot(y_q);

    pri_encoder_comb #(.N(N), .W(W)) u_pri_pend (
        .vec_i (p_q),
        .idx_o (p_idx_c),
        .any_o (p_any_c)
    );

    pri_encoder_comb #(.N(N), .W(W)) u_pri_rem (
        .vec_i (rem_c),
        .idx_o (rem_idx_c),
        .any_o (rem_any_c)
    );

    // Offered index is held stable until accepted; no preemption by newer requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            y_q     <= '0;
            v_q     <= 1'b0;
            o_q     <= 1'b0;
        end else begin
            p_q <= p_d;
            o_q <= o_d;
            case (state_q)
                ST_IDLE: begin
                    if (p_any_c) begin
                        y_q     <= p_idx_c;
                        v_q     <= 1'b1;
                        state_q <= ST_OFFER;
                    end else begin
                        v_q <= 1'b0;
                    end
                end
                default: begin
                    if (R) begin
                        if (rem_any_c) begin
                            y_q <= rem_idx_c;
                        end else begin
                            v_q     <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign Y = y_q;
    assign V = v_q;
    assign O = o_q;

endmodule
